// File: rtl/xdisp_ctrl.sv
// Memory-mapped 4-digit seven-segment display driver: register file, digit scan
// with frame-boundary commit of the displayed value, and registered segment/anode outputs.
module xdisp_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        Disp,
    output logic [3:0]        Disp_sel
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]       r_pending;
    logic [15:0]       r_shadow;
    logic [3:0]        r_dp;
    logic [3:0]        r_blank;
    logic              r_en;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_data_out;
    logic [7:0]        r_disp;
    logic [3:0]        r_disp_sel;

    logic              w_wr;
    logic              w_rd;
    logic              w_tick;
    logic              w_en_rise;
    logic              w_frame_wrap;
    logic              w_show;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg;
    logic [DATA_W-1:0] w_rdata;

    assign w_wr         = sel & we;
    assign w_rd         = sel & ~we;
    assign w_tick       = r_en & (r_cnt == CNT_MAX);
    assign w_en_rise    = w_wr & (addr == 2'd2) & data_in[0] & ~r_en;
    assign w_frame_wrap = w_tick & (r_idx == 2'd3);

    // Software-visible registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 16'h0000;
            r_dp      <= 4'h0;
            r_blank   <= 4'h0;
            r_en      <= 1'b0;
        end else if (w_wr) begin
            case (addr)
                2'd0: r_pending <= data_in[15:0];
                2'd1: begin
                    r_dp    <= data_in[3:0];
                    r_blank <= data_in[7:4];
                end
                2'd2: r_en <= data_in[0];
                default: ;
            endcase
        end
    end

    // Digit scan; shadow takes the pre-edge pending value on enable or frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_shadow <= 16'h0000;
        end else if (w_en_rise) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_shadow <= r_pending;
        end else begin
            if (!r_en || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_frame_wrap) begin
                r_shadow <= r_pending;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (addr)
            2'd0: w_rdata = DATA_W'(r_pending);
            2'd1: w_rdata = DATA_W'({r_blank, r_dp});
            2'd2: w_rdata = DATA_W'(r_en);
            default: w_rdata = DATA_W'(r_shadow);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd) begin
            r_data_out <= w_rdata;
        end
    end

    assign w_nib  = r_shadow[{r_idx, 2'b00} +: 4];
    assign w_show = r_en & ~r_blank[r_idx];

    // Active-low a..g hex glyphs, lowercase b and d
    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            default: w_seg = 7'b0111000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp     <= 8'hFF;
            r_disp_sel <= 4'hF;
        end else if (w_show) begin
            r_disp     <= {w_seg, ~r_dp[r_idx]};
            r_disp_sel <= ~(4'b0001 << r_idx);
        end else begin
            r_disp     <= 8'hFF;
            r_disp_sel <= 4'hF;
        end
    end

    assign data_out = r_data_out;
    assign Disp     = r_disp;
    assign Disp_sel = r_disp_sel;

endmodule

// File: tb/tb_xdisp_ctrl.sv
// Scoreboard bench for xdisp_ctrl: a cycle model queues expected display and read
// data at each edge; the queue is drained against the DUT on the falling edge.
module tb_xdisp_ctrl;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data_in = 16'h0;
    logic [15:0] data_out;
    logic [7:0]  Disp;
    logic [3:0]  Disp_sel;

    int n_checks = 0;
    int n_errors = 0;

    xdisp_ctrl #(.REFRESH_DIV(DIV), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .Disp(Disp), .Disp_sel(Disp_sel)
    );

    always #5 clk = ~clk;

    logic [6:0] SEG [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] m_pend = 0, m_shadow = 0, m_old_pend;
    logic [3:0]  m_dp = 0, m_blank = 0;
    logic        m_en = 0, m_old_en, m_tick, m_rise;
    logic [1:0]  m_idx = 0;
    int          m_cnt = 0;
    logic [11:0] dq[$];
    logic [15:0] rq[$];
    logic [11:0] e_disp;
    logic [15:0] e_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_shadow = 0; m_dp = 0; m_blank = 0;
            m_en = 0; m_idx = 0; m_cnt = 0;
            dq.delete(); rq.delete();
        end else begin
            if (!m_en || m_blank[m_idx])
                dq.push_back({4'hF, 8'hFF});
            else
                dq.push_back({~(4'b0001 << m_idx), SEG[m_shadow[m_idx*4 +: 4]], ~m_dp[m_idx]});
            if (sel && !we) begin
                case (addr)
                    2'd0: rq.push_back(m_pend);
                    2'd1: rq.push_back({8'h00, m_blank, m_dp});
                    2'd2: rq.push_back({15'h0, m_en});
                    default: rq.push_back(m_shadow);
                endcase
            end
            m_old_pend = m_pend;
            m_old_en   = m_en;
            m_tick     = m_en && (m_cnt == DIV - 1);
            m_rise     = sel && we && addr == 2'd2 && data_in[0] && !m_en;
            if (m_rise) begin
                m_cnt = 0; m_idx = 0; m_shadow = m_old_pend;
            end else begin
                if (m_tick && m_idx == 2'd3) m_shadow = m_old_pend;
                if (m_tick) m_idx = m_idx + 2'd1;
                m_cnt = (!m_old_en || m_tick) ? 0 : m_cnt + 1;
            end
            if (sel && we) begin
                case (addr)
                    2'd0: m_pend = data_in;
                    2'd1: begin m_dp = data_in[3:0]; m_blank = data_in[7:4]; end
                    2'd2: m_en = data_in[0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_disp", 32'(Disp), 32'hFF);
            check("rst_sel", 32'(Disp_sel), 32'hF);
            check("rst_dout", 32'(data_out), 32'h0);
        end else begin
            if (dq.size() > 0) begin
                e_disp = dq.pop_front();
                check("disp", 32'(Disp), 32'(e_disp[7:0]));
                check("disp_sel", 32'(Disp_sel), 32'(e_disp[11:8]));
            end
            if (rq.size() > 0) begin
                e_rd = rq.pop_front();
                check("rdata", 32'(data_out), 32'(e_rd));
            end
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0; data_in = 16'h0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        sel = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_model(input logic [1:0] i, input int c);
        int n = 0;
        while (!(m_en && m_idx == i && m_cnt == c) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("wait_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] sel_e [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg_e [4] = '{8'h99, 8'h0D, 8'h25, 8'h9F};

    initial begin
        cycles(3);
        rst = 1'b0;
        cycles(2);
        check("init_disp", 32'(Disp), 32'hFF);
        check("init_sel", 32'(Disp_sel), 32'hF);
        bus_rd(2'd3);
        cycles(1);

        // Scan of 1234 with fixed expectations
        bus_wr(2'd0, 16'h1234);
        bus_wr(2'd2, 16'h0001);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < DIV; c++) begin
                @(posedge clk); #1;
                check("scan_sel", 32'(Disp_sel), 32'(sel_e[d]));
                check("scan_disp", 32'(Disp), 32'(seg_e[d]));
            end
        end

        // Mid-frame value update waits for the wrap
        wait_model(2'd1, 1);
        bus_wr(2'd0, 16'hA8F0);
        bus_rd(2'd3);
        wait_model(2'd0, 1);
        bus_rd(2'd3);
        cycles(4 * DIV);

        // Write on the exact wrap edge
        wait_model(2'd3, DIV - 1);
        bus_wr(2'd0, 16'h5555);
        bus_rd(2'd3);
        cycles(4 * DIV);
        bus_rd(2'd3);
        cycles(2);

        // dp on digit 0, blank digit 1
        bus_wr(2'd1, 16'h0021);
        cycles(2 * 4 * DIV);
        bus_rd(2'd1);

        // Disable, then RO write ignored
        bus_wr(2'd2, 16'h0000);
        @(posedge clk); #1;
        check("dis_disp", 32'(Disp), 32'hFF);
        check("dis_sel", 32'(Disp_sel), 32'hF);
        bus_wr(2'd3, 16'hFFFF);
        bus_rd(2'd3);
        bus_rd(2'd0);
        bus_rd(2'd2);
        cycles(2);

        // Mid-scan asynchronous reset
        bus_wr(2'd1, 16'h0000);
        bus_wr(2'd2, 16'h0001);
        cycles(6);
        rst = 1'b1;
        #1;
        check("amid_disp", 32'(Disp), 32'hFF);
        check("amid_sel", 32'(Disp_sel), 32'hF);
        check("amid_dout", 32'(data_out), 32'h0);
        cycles(2);
        rst = 1'b0;
        cycles(2);
        bus_rd(2'd3);
        bus_rd(2'd0);
        cycles(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
